mac_tx_arbiter: RTL and testbench
=================================

Name: mac_tx_arbiter

Overview:
- Frame-level arbiter that shares the single MAC transmit byte stream between two requesters, e.g. two bridge-forwarding FIFOs.
- Grants whole frames only and uses round robin between requesters.
- Inserts a programmable inter-frame idle gap.
- Truncates oversize frames and flags them with tx_mac_err.
- Sits between the bridge FIFOs and the MAC TX byte interface, in the tx_mac_clk domain.

Parameters:
- MAX_LEN, 1518, maximum bytes per frame before forced truncation; valid range 64..2047.
- IFG_CYCLES, 12, idle cycles forced after each frame's last byte; 0 means none.

Ports:
- tx_mac_clk  in  1  MAC TX byte clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_data  in  8  requester 0 byte.
- req0_valid  in  1  requester 0 byte valid.
- req0_last  in  1  requester 0 final byte of frame.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_data, req1_valid, req1_last, req1_ready: same as requester 0, for requester 1.
- tx_mac_data  out  8  byte to MAC.
- tx_mac_valid  out  1  byte valid to MAC.
- tx_mac_last  out  1  final byte of frame to MAC.
- tx_mac_err  out  1  qualifies the last byte; frame was truncated.
- tx_mac_ready  in  1  MAC accepts byte.
- grant  out  2  one-hot owner of the current frame; 00 when idle.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - grant=00, busy=0; all ready/valid/last/err outputs 0; tx_mac_data=0.
  - Length and gap counters 0; rr pointer set so requester 0 wins the first contention.
  - Reset mid-frame abandons the frame silently; requesters are reset alongside.
- Handshake: a byte transfers when valid && ready are both 1 on a clock edge. A valid byte holds its data/last until accepted.
- IDLE:
  - Evaluates req0_valid and req1_valid. One asserted: grant it. Both asserted: grant the requester not served last, then flip the pointer.
  - grant is registered, so the first byte appears on tx_mac_* the cycle after the request is seen. Latency is 1 cycle.
- XFER:
  - tx_mac_data/valid/last are a combinational mux of the granted requester.
  - reqN_ready = tx_mac_ready for the granted N; 0 for the other requester.
  - len_cnt (11 bits) increments per transferred byte.
  - Transfer with last=1: go to GAP; tx_mac_err=0.
  - Transfer where len_cnt reaches MAX_LEN without last: that byte goes out with tx_mac_last=1 and tx_mac_err=1.
    - If the requester's last coincides with the truncation byte, go to GAP.
    - Otherwise go to DRAIN.
- DRAIN:
  - tx_mac_valid=0; granted reqN_ready=1.
  - Discards bytes up to and including the requester's last byte, then goes to GAP.
- GAP:
  - Loads IFG_CYCLES on entry; tx_mac_valid=0, all ready 0.
  - Decrements to 0, then goes to IDLE; grant clears on entry to IDLE.
  - IFG_CYCLES=0: GAP lasts 0 cycles and the state goes straight to IDLE.
  - Requests arriving during GAP wait; arbitration happens only in IDLE.
- Boundary cases:
  - 1-byte frame (valid && last on the first byte) is legal.
  - A requester dropping valid mid-frame stalls the output. The grant is held and there is no timeout.
  - tx_mac_ready low holds the byte at the requester.

Optional Feature:
- Macro MAC_TX_ARB_STATS_EN.
- Defined:
  - Adds output ports frm_cnt0 (16), frm_cnt1 (16) and trunc_cnt (16).
  - frm_cntN increments on each completed frame from requester N, truncated frames included. trunc_cnt increments on each truncation.
  - All three are saturating and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package eth_bridge_pkg holds:
  - the state encoding: IDLE, XFER, DRAIN, GAP;
  - ETH_MAX_FRAME=1518 and ETH_IFG_BYTES=12 as defaults;
  - the byte-width constant 8.
- Sub-module rr_arb2: 2-way round-robin picker with req[1:0], an update strobe, and a one-hot grant. Pointer update is internal.

Test Plan:
- Single request: req0 sends a 64-byte frame with tx_mac_ready=1 -> grant=01 one cycle later; 64 bytes out in order; tx_mac_last on byte 64; then 12 idle cycles; then grant=00.
- Contention: both requesters valid in the same cycle after reset -> req0 served first, then req1, then req0 again when both stay pending; frames never interleave.
- Backpressure: tx_mac_ready toggles 1,0,1,0 during a 100-byte frame -> 100 bytes out with no loss or duplication; reqN_ready mirrors tx_mac_ready.
- Oversize: MAX_LEN=64, req1 sends 80 bytes -> byte 64 has tx_mac_last=1 and tx_mac_err=1; bytes 65-80 are consumed with no output; then GAP.
- Reset mid-frame: reset low at byte 30 -> all outputs 0 asynchronously; after release, the next request is granted with a fresh len_cnt.
- IFG_CYCLES=0 with back-to-back 1-byte frames from req0 -> next grant one cycle after the last byte; the IDLE arbitration cycle is the only idle slot.

Source files
------------

// File: rtl/eth_bridge_pkg.sv
// Shared constants and FSM encoding for the bridge TX path.
// Used by mac_tx_arbiter and its interface.
package eth_bridge_pkg;
   localparam int ETH_MAX_FRAME = 1518;
   localparam int ETH_IFG_BYTES = 12;
   localparam int BYTE_W        = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_XFER  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;
endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Byte-stream bundle: two requester ports plus the MAC TX side.
interface mac_tx_arbiter_if;
   import eth_bridge_pkg::*;

   logic [BYTE_W-1:0] req0_data;
   logic              req0_valid;
   logic              req0_last;
   logic              req0_ready;
   logic [BYTE_W-1:0] req1_data;
   logic              req1_valid;
   logic              req1_last;
   logic              req1_ready;
   logic [BYTE_W-1:0] tx_mac_data;
   logic              tx_mac_valid;
   logic              tx_mac_last;
   logic              tx_mac_err;
   logic              tx_mac_ready;
   logic [1:0]        grant;
   logic              busy;

   modport master (
      output req0_data, req0_valid, req0_last,
      input  req0_ready,
      output req1_data, req1_valid, req1_last,
      input  req1_ready,
      input  tx_mac_data, tx_mac_valid, tx_mac_last, tx_mac_err,
      output tx_mac_ready,
      input  grant, busy
   );

   modport slave (
      input  req0_data, req0_valid, req0_last,
      output req0_ready,
      input  req1_data, req1_valid, req1_last,
      output req1_ready,
      output tx_mac_data, tx_mac_valid, tx_mac_last, tx_mac_err,
      input  tx_mac_ready,
      output grant, busy
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; ptr_q names the preferred requester.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   output logic [1:0] gnt_o
);
   logic ptr_q, ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      if (ptr_q) begin
         if (req_i[1])      gnt_o = 2'b10;
         else if (req_i[0]) gnt_o = 2'b01;
      end else begin
         if (req_i[0])      gnt_o = 2'b01;
         else if (req_i[1]) gnt_o = 2'b10;
      end
   end

   // After serving requester 0, prefer requester 1 next, and vice versa.
   assign ptr_d = (upd_i && gnt_o != 2'b00) ? gnt_o[0] : ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-level round-robin arbiter onto the MAC TX byte stream.
// Define MAC_TX_ARB_STATS_EN to add frame/truncation counters.
module mac_tx_arbiter
   import eth_bridge_pkg::*;
#(
   parameter int MAX_LEN    = ETH_MAX_FRAME,
   parameter int IFG_CYCLES = ETH_IFG_BYTES
) (
   input logic             tx_mac_clk,
   input logic             reset,
   mac_tx_arbiter_if.slave bus
`ifdef MAC_TX_ARB_STATS_EN
   ,
   output logic [15:0]     frm_cnt0,
   output logic [15:0]     frm_cnt1,
   output logic [15:0]     trunc_cnt
`endif
);
   localparam logic [10:0] LEN_LIM = 11'(MAX_LEN - 1);
   localparam logic [15:0] GAP_LD  = 16'(IFG_CYCLES);

   logic [1:0]        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic [10:0]       len_q, len_d;
   logic [15:0]       gap_q, gap_d;
   logic [1:0]        pick;
   logic              upd;
   logic [BYTE_W-1:0] sel_data;
   logic              sel_valid, sel_last;
   logic              in_xfer, in_drain;
   logic              xfer, trunc, done, rdy;

   rr_arb2 u_rr (
      .clk   (tx_mac_clk),
      .rst_n (reset),
      .req_i ({bus.req1_valid, bus.req0_valid}),
      .upd_i (upd),
      .gnt_o (pick)
   );

   assign sel_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
   assign sel_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
   assign sel_last  = grant_q[1] ? bus.req1_last  : bus.req0_last;

   assign in_xfer  = (state_q == ST_XFER);
   assign in_drain = (state_q == ST_DRAIN);
   assign xfer     = in_xfer && sel_valid && bus.tx_mac_ready;
   assign trunc    = (len_q == LEN_LIM);
   assign done     = (xfer && sel_last) || (in_drain && sel_valid && sel_last);
   assign rdy      = in_xfer ? bus.tx_mac_ready : in_drain;

   assign bus.tx_mac_valid = in_xfer && sel_valid;
   assign bus.tx_mac_data  = in_xfer ? sel_data : '0;
   assign bus.tx_mac_last  = in_xfer && sel_valid && (sel_last || trunc);
   assign bus.tx_mac_err   = in_xfer && sel_valid && trunc && !sel_last;
   assign bus.req0_ready   = rdy && grant_q[0];
   assign bus.req1_ready   = rdy && grant_q[1];
   assign bus.grant        = grant_q;
   assign bus.busy         = (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      len_d   = len_q;
      gap_d   = gap_q;
      upd     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick != 2'b00) begin
               state_d = ST_XFER;
               grant_d = pick;
               len_d   = '0;
               upd     = 1'b1;
            end
         end
         ST_XFER: begin
            if (xfer) begin
               len_d = len_q + 11'd1;
               if (!sel_last && trunc) state_d = ST_DRAIN;
            end
         end
         ST_GAP: begin
            if (gap_q <= 16'd1) begin
               state_d = ST_IDLE;
               grant_d = 2'b00;
            end else begin
               gap_d = gap_q - 16'd1;
            end
         end
         default: ;
      endcase
      // Frame end: a zero gap skips GAP entirely.
      if (done) begin
         if (IFG_CYCLES == 0) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LD;
         end
      end
   end

   always_ff @(posedge tx_mac_clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         grant_q <= 2'b00;
         len_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
      end
   end

`ifdef MAC_TX_ARB_STATS_EN
   logic [15:0] frm0_q, frm1_q, trc_q;
   logic        trunc_ev;

   assign trunc_ev = xfer && trunc && !sel_last;

   always_ff @(posedge tx_mac_clk or negedge reset) begin
      if (!reset) begin
         frm0_q <= '0;
         frm1_q <= '0;
         trc_q  <= '0;
      end else begin
         if (done && grant_q[0] && frm0_q != 16'hFFFF) frm0_q <= frm0_q + 16'd1;
         if (done && grant_q[1] && frm1_q != 16'hFFFF) frm1_q <= frm1_q + 16'd1;
         if (trunc_ev && trc_q != 16'hFFFF)            trc_q  <= trc_q + 16'd1;
      end
   end

   assign frm_cnt0  = frm0_q;
   assign frm_cnt1  = frm1_q;
   assign trunc_cnt = trc_q;
`endif
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench: one default instance and one with MAX_LEN=64,
// IFG_CYCLES=0; requesters are queue-fed byte sources.
`timescale 1ns/1ps
module tb_mac_tx_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mac_tx_arbiter_if ifb ();
   mac_tx_arbiter_if ifa ();

   // Source index 0/1 feed ifb req0/req1, 2/3 feed ifa req0/req1.
   logic [7:0] rd [4];
   logic       rv [4];
   logic       rl [4];
   logic       acc [4];
   wire        rr [4];
   logic [8:0] sq [4][$];
   logic [9:0] ob [$];
   logic [9:0] oa [$];

   assign ifb.req0_data  = rd[0];
   assign ifb.req0_valid = rv[0];
   assign ifb.req0_last  = rl[0];
   assign ifb.req1_data  = rd[1];
   assign ifb.req1_valid = rv[1];
   assign ifb.req1_last  = rl[1];
   assign ifa.req0_data  = rd[2];
   assign ifa.req0_valid = rv[2];
   assign ifa.req0_last  = rl[2];
   assign ifa.req1_data  = rd[3];
   assign ifa.req1_valid = rv[3];
   assign ifa.req1_last  = rl[3];
   assign rr[0] = ifb.req0_ready;
   assign rr[1] = ifb.req1_ready;
   assign rr[2] = ifa.req0_ready;
   assign rr[3] = ifa.req1_ready;

`ifdef MAC_TX_ARB_STATS_EN
   wire [15:0] sb0, sb1, sbt, sa0, sa1, sat;
   mac_tx_arbiter u_b (
      .tx_mac_clk(clk), .reset(rst_n), .bus(ifb),
      .frm_cnt0(sb0), .frm_cnt1(sb1), .trunc_cnt(sbt)
   );
   mac_tx_arbiter #(.MAX_LEN(64), .IFG_CYCLES(0)) u_a (
      .tx_mac_clk(clk), .reset(rst_n), .bus(ifa),
      .frm_cnt0(sa0), .frm_cnt1(sa1), .trunc_cnt(sat)
   );
`else
   mac_tx_arbiter u_b (
      .tx_mac_clk(clk), .reset(rst_n), .bus(ifb)
   );
   mac_tx_arbiter #(.MAX_LEN(64), .IFG_CYCLES(0)) u_a (
      .tx_mac_clk(clk), .reset(rst_n), .bus(ifa)
   );
`endif

   // Byte sources: hold the head byte until a handshake is seen.
   initial begin
      for (int i = 0; i < 4; i++) begin
         rv[i] = 1'b0; rd[i] = 8'h0; rl[i] = 1'b0; acc[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) acc[i] = rv[i] && rr[i];
         @(posedge clk);
         #2;
         for (int i = 0; i < 4; i++) begin
            if (acc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
            rv[i] = (sq[i].size() > 0);
            if (rv[i]) {rl[i], rd[i]} = sq[i][0];
            else       {rl[i], rd[i]} = 9'h0;
         end
      end
   end

   // Output capture: {err, last, data} for every accepted MAC byte.
   initial forever begin
      @(negedge clk);
      if (ifb.tx_mac_valid && ifb.tx_mac_ready)
         ob.push_back({ifb.tx_mac_err, ifb.tx_mac_last, ifb.tx_mac_data});
      if (ifa.tx_mac_valid && ifa.tx_mac_ready)
         oa.push_back({ifa.tx_mac_err, ifa.tx_mac_last, ifa.tx_mac_data});
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int i, input int n, input int base);
      for (int k = 1; k <= n; k++)
         sq[i].push_back({(k == n), 8'(base + k)});
   endtask

   task automatic wait_out(input bit a, input int n, input int budget,
                           input string tag);
      int c = 0;
      while (((a ? oa.size() : ob.size()) < n) && c < budget) begin
         @(negedge clk);
         #1;
         c++;
      end
      chk(tag, a ? oa.size() : ob.size(), n);
   endtask

   task automatic wait_idle(input bit a, input string tag);
      for (int c = 0; c < 60; c++) begin
         if ((a ? ifa.grant : ifb.grant) == 2'b00) break;
         @(negedge clk);
         #1;
      end
      chk(tag, a ? ifa.grant : ifb.grant, 2'b00);
   endtask

   task automatic frame_chk(input bit a, input int start, input int n,
                            input int base, input bit err_last,
                            input string tag);
      int         bad = 0;
      int         idx;
      logic [9:0] e, g;
      for (int k = 1; k <= n; k++) begin
         idx = start + k - 1;
         e = {(err_last && k == n), (k == n), 8'(base + k)};
         if (a) g = (idx < oa.size()) ? oa[idx] : 10'h3FF;
         else   g = (idx < ob.size()) ? ob[idx] : 10'h3FF;
         if (g !== e) bad++;
      end
      chk(tag, bad, 0);
   endtask

   int         gapc, bad, mis, ns, leak, rmiss, found, base;
   logic [7:0] vpat;
   logic [1:0] g2;
   logic [9:0] e;

   initial begin
      ifb.tx_mac_ready = 1'b1;
      ifa.tx_mac_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", ifb.grant, 2'b00);
      chk("rst_busy", ifb.busy, 1'b0);
      chk("rst_valid", ifb.tx_mac_valid, 1'b0);
      chk("rst_data", ifb.tx_mac_data, 8'h00);
      chk("rst_ready", {ifb.req1_ready, ifb.req0_ready}, 2'b00);
      chk("rst_last_err", {ifb.tx_mac_last, ifb.tx_mac_err}, 2'b00);
      tick();
      rst_n = 1'b1;
      tick();

      // Single 64-byte frame from req0 with a 12-cycle gap.
      push(0, 64, 0);
      @(negedge clk);
      chk("t1_grant_early", ifb.grant, 2'b00);
      @(negedge clk);
      chk("t1_grant", ifb.grant, 2'b01);
      chk("t1_first", {ifb.tx_mac_valid, ifb.tx_mac_data}, {1'b1, 8'd1});
      wait_out(0, 64, 200, "t1_count");
      gapc = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ifb.grant == 2'b00) break;
         if (!ifb.tx_mac_valid) gapc++;
      end
      chk("t1_gap", gapc, 12);
      chk("t1_idle_grant", ifb.grant, 2'b00);
      frame_chk(0, 0, 64, 0, 1'b0, "t1_frame");

      // Contention right after reset: req0, req1, req0, req1.
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      ob.delete();
      push(0, 3, 'hA0);
      push(0, 3, 'hA3);
      push(1, 3, 'hB0);
      push(1, 3, 'hB3);
      @(negedge clk);
      @(negedge clk);
      chk("t2_first_grant", ifb.grant, 2'b01);
      wait_out(0, 12, 300, "t2_count");
      bad = 0;
      for (int f = 0; f < 4; f++) begin
         base = ((f % 2) != 0 ? 'hB0 : 'hA0) + (f / 2) * 3;
         for (int k = 1; k <= 3; k++) begin
            e = {1'b0, (k == 3), 8'(base + k)};
            if (ob[f * 3 + k - 1] !== e) bad++;
         end
      end
      chk("t2_order", bad, 0);
      wait_idle(0, "t2_idle");

      // Backpressure: tx_mac_ready toggles during a 100-byte frame.
      tick();
      ob.delete();
      push(1, 100, 'h10);
      mis = 0;
      ns = 0;
      for (int c = 0; c < 400 && ob.size() < 100; c++) begin
         @(posedge clk);
         #1;
         ifb.tx_mac_ready = ~ifb.tx_mac_ready;
         @(negedge clk);
         #1;
         if (ifb.tx_mac_valid && ifb.grant == 2'b10) begin
            ns++;
            if (ifb.req1_ready !== ifb.tx_mac_ready || ifb.req0_ready !== 1'b0)
               mis++;
         end
      end
      ifb.tx_mac_ready = 1'b1;
      chk("t3_mirror", mis, 0);
      chk("t3_sampled", (ns > 150), 1'b1);
      chk("t3_count", ob.size(), 100);
      frame_chk(0, 0, 100, 'h10, 1'b0, "t3_frame");
      wait_idle(0, "t3_idle");

      // Reset mid-frame on the short-MAX_LEN instance.
      tick();
      oa.delete();
      push(2, 50, 0);
      found = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         #1;
         if (ifa.tx_mac_valid && ifa.tx_mac_data == 8'd30) begin
            found = 1;
            break;
         end
      end
      chk("t4_reach30", found, 1);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_grant", ifa.grant, 2'b00);
      chk("t4_rst_busy", ifa.busy, 1'b0);
      chk("t4_rst_out",
          {ifa.tx_mac_valid, ifa.tx_mac_last, ifa.tx_mac_err, ifa.tx_mac_data},
          11'h0);
      chk("t4_rst_ready", {ifa.req1_ready, ifa.req0_ready}, 2'b00);
      sq[2].delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      oa.delete();
      push(2, 50, 'h40);
      wait_out(1, 50, 200, "t4_count");
      frame_chk(1, 0, 50, 'h40, 1'b0, "t4_frame");
      wait_idle(1, "t4_idle");

      // Oversize: 80 bytes against MAX_LEN=64.
      tick();
      oa.delete();
      push(3, 80, 0);
      wait_out(1, 64, 200, "t5_count");
      frame_chk(1, 0, 64, 0, 1'b1, "t5_frame");
      leak = 0;
      rmiss = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         #1;
         if (ifa.tx_mac_valid) leak++;
         if (ifa.grant == 2'b10 && ifa.req1_ready !== 1'b1) rmiss++;
         if (sq[3].size() == 0) break;
      end
      chk("t5_leak", leak, 0);
      chk("t5_drain_ready", rmiss, 0);
      chk("t5_drained", sq[3].size(), 0);
      chk("t5_idle", ifa.grant, 2'b00);
      chk("t5_total", oa.size(), 64);

      // Zero gap with back-to-back 1-byte frames from req0.
      tick();
      oa.delete();
      push(2, 1, 'hD0);
      push(2, 1, 'hD1);
      push(2, 1, 'hD2);
      vpat = 8'h0;
      g2 = 2'b11;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         vpat[i] = ifa.tx_mac_valid;
         if (i == 2) g2 = ifa.grant;
      end
      chk("t6_pattern", vpat, 8'h2A);
      chk("t6_gap_grant", g2, 2'b00);
      chk("t6_count", oa.size(), 3);
      frame_chk(1, 0, 1, 'hD0, 1'b0, "t6_f1");
      frame_chk(1, 1, 1, 'hD1, 1'b0, "t6_f2");
      frame_chk(1, 2, 1, 'hD2, 1'b0, "t6_f3");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
